// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: freeze on memory busywait,
// multi-cycle divide occupancy, branch redirect and load-use interlock.
module pipeline_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_busywait_i,
  input  logic        dmem_busywait_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_mem_read_i,
  input  logic        branch_taken_i,
  input  logic        div_start_i,
  input  logic        clr_stall_count_i,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        id_ex_hold_o,
  output logic        ex_mem_hold_o,
  output logic        mem_wb_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_flush_o,
  output logic        div_busy_o,
  output logic [15:0] stall_count_o
);

  typedef enum logic {
    S_RUN      = 1'b0,
    S_DIV_BUSY = 1'b1
  } state_e;

  localparam logic [15:0] DIV_LOAD = 16'(DIV_CYCLES - 32'd2);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic freeze;
  logic div_occupy;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign freeze     = imem_busywait_i | dmem_busywait_i;
  assign div_occupy = ((state_q == S_DIV_BUSY) && (cnt_q != 16'd0)) ||
                      ((state_q == S_RUN) && div_start_i);
  assign rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
  assign load_use   = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

  // Priority resolution of the hazard rules and next-state of the divide sequencer
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_hold_o      = 1'b0;
    if_id_hold_o   = 1'b0;
    id_ex_hold_o   = 1'b0;
    ex_mem_hold_o  = 1'b0;
    mem_wb_hold_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    if (!rst_n || freeze) begin
      // Reset and busywait both park every stage; sequencer state is untouched.
      pc_hold_o     = 1'b1;
      if_id_hold_o  = 1'b1;
      id_ex_hold_o  = 1'b1;
      ex_mem_hold_o = 1'b1;
      mem_wb_hold_o = 1'b1;
    end else if (div_occupy) begin
      pc_hold_o      = 1'b1;
      if_id_hold_o   = 1'b1;
      id_ex_hold_o   = 1'b1;
      ex_mem_flush_o = 1'b1;
      if (state_q == S_RUN) begin
        state_d = S_DIV_BUSY;
        cnt_d   = DIV_LOAD;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end else if (state_q == S_DIV_BUSY) begin
      // Release cycle: EX/MEM captures the divider result, new DIV_START ignored.
      state_d = S_RUN;
    end else if (branch_taken_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_hold_o     = 1'b1;
      if_id_hold_o  = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

  // Saturating stall-cycle counter, clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stall_count_i) begin
      stall_cnt_d = 16'd0;
    end else if (pc_hold_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, divide down-counter and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      cnt_q       <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign div_busy_o    = (state_q == S_DIV_BUSY);
  assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl plus hand sequences for
// reset-mid-divide and stall counter saturation.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic imem, dmem, u1, u2, memrd, br, div_start, clr;
  logic [4:0] rs1, rs2, exrd;

  logic pc_h, ifid_h, idex_h, exmem_h, memwb_h, ifid_f, idex_f, exmem_f, busy;
  logic [15:0] scnt;
  logic l_pc_h, l_ifid_h, l_idex_h, l_exmem_h, l_memwb_h, l_ifid_f, l_idex_f, l_exmem_f, l_busy;
  logic [15:0] l_scnt;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DIV_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_busywait_i(imem), .dmem_busywait_i(dmem),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
    .ex_rd_i(exrd), .ex_mem_read_i(memrd), .branch_taken_i(br),
    .div_start_i(div_start), .clr_stall_count_i(clr),
    .pc_hold_o(pc_h), .if_id_hold_o(ifid_h), .id_ex_hold_o(idex_h),
    .ex_mem_hold_o(exmem_h), .mem_wb_hold_o(memwb_h),
    .if_id_flush_o(ifid_f), .id_ex_flush_o(idex_f), .ex_mem_flush_o(exmem_f),
    .div_busy_o(busy), .stall_count_o(scnt)
  );

  pipeline_hazard_ctrl #(.DIV_CYCLES(12)) u_dut_long (
    .clk(clk), .rst_n(rst_n),
    .imem_busywait_i(imem), .dmem_busywait_i(dmem),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
    .ex_rd_i(exrd), .ex_mem_read_i(memrd), .branch_taken_i(br),
    .div_start_i(div_start), .clr_stall_count_i(clr),
    .pc_hold_o(l_pc_h), .if_id_hold_o(l_ifid_h), .id_ex_hold_o(l_idex_h),
    .ex_mem_hold_o(l_exmem_h), .mem_wb_hold_o(l_memwb_h),
    .if_id_flush_o(l_ifid_f), .id_ex_flush_o(l_idex_f), .ex_mem_flush_o(l_exmem_f),
    .div_busy_o(l_busy), .stall_count_o(l_scnt)
  );

  typedef struct {
    string      name;
    logic [1:0] bw;     // {imem, dmem}
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] uses;   // {uses_rs1, uses_rs2}
    logic [4:0] exrd;
    logic       memrd;
    logic       br;
    logic       div;
    logic [4:0] hold;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0] flush;  // {if_id, id_ex, ex_mem}
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [1:0] bw, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [1:0] uses, input logic [4:0] rd, input logic mr, input logic b,
                     input logic d, input logic [4:0] h, input logic [2:0] f, input logic bz);
    vec_t v;
    v.name = n; v.bw = bw; v.rs1 = r1; v.rs2 = r2; v.uses = uses; v.exrd = rd;
    v.memrd = mr; v.br = b; v.div = d; v.hold = h; v.flush = f; v.busy = bz;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    {imem, dmem} = v.bw;
    rs1 = v.rs1; rs2 = v.rs2; {u1, u2} = v.uses; exrd = v.exrd;
    memrd = v.memrd; br = v.br; div_start = v.div;
    @(negedge clk);
    check({v.name, ".hold"}, {27'd0, pc_h, ifid_h, idex_h, exmem_h, memwb_h}, {27'd0, v.hold});
    check({v.name, ".flush"}, {29'd0, ifid_f, idex_f, exmem_f}, {29'd0, v.flush});
    check({v.name, ".busy"}, {31'd0, busy}, {31'd0, v.busy});
    check({v.name, ".scnt"}, {16'd0, scnt}, model_cnt);
    if (v.hold[4]) model_cnt++;
  endtask

  task automatic idle_inputs();
    imem = 1'b0; dmem = 1'b0; u1 = 1'b0; u2 = 1'b0; memrd = 1'b0;
    br = 1'b0; div_start = 1'b0; clr = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; exrd = 5'd0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // single-cycle hazard vectors
    add("idle",        2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0);
    add("lu_rs2",      2'b00, 5'd0, 5'd5, 2'b01, 5'd5, 1'b1, 1'b0, 1'b0, 5'b11000, 3'b010, 1'b0);
    add("after_lu",    2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0);
    add("lu_x0",       2'b00, 5'd0, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0);
    add("lu_rs1_unused", 2'b00, 5'd9, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0);
    add("lu_rs1",      2'b00, 5'd7, 5'd3, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0, 5'b11000, 3'b010, 1'b0);
    add("no_load",     2'b00, 5'd7, 5'd3, 2'b11, 5'd7, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0);
    add("lu_miss",     2'b00, 5'd6, 5'd3, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0);
    add("br_over_lu",  2'b00, 5'd0, 5'd5, 2'b01, 5'd5, 1'b1, 1'b1, 1'b0, 5'b00000, 3'b110, 1'b0);
    add("imem_frz",    2'b10, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11111, 3'b000, 1'b0);
    add("dmem_frz",    2'b01, 5'd0, 5'd5, 2'b01, 5'd5, 1'b1, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0);
    add("idle2",       2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0);
    // divide, DIV_CYCLES = 4; release cycle ignores DIV_START
    add("div_c1",      2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11100, 3'b001, 1'b0);
    add("div_c2",      2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11100, 3'b001, 1'b1);
    add("div_c3",      2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11100, 3'b001, 1'b1);
    add("div_c4_rel",  2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b00000, 3'b000, 1'b1);
    add("div_after",   2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0);
    // divide with two freeze cycles mid-way: six cycles total
    add("dfz_c1",      2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11100, 3'b001, 1'b0);
    add("dfz_c2",      2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11100, 3'b001, 1'b1);
    add("dfz_c3_frz",  2'b01, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11111, 3'b000, 1'b1);
    add("dfz_c4_frz",  2'b01, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11111, 3'b000, 1'b1);
    add("dfz_c5",      2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11100, 3'b001, 1'b1);
    add("dfz_c6_rel",  2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b00000, 3'b000, 1'b1);
    add("dfz_after",   2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0);
    // busywait in the DIV_START cycle keeps the block in RUN
    add("dsb_frz",     2'b10, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11111, 3'b000, 1'b0);
    add("dsb_c1",      2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11100, 3'b001, 1'b0);
    add("dsb_c2",      2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11100, 3'b001, 1'b1);
    add("dsb_c3",      2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11100, 3'b001, 1'b1);
    add("dsb_rel",     2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 5'b00000, 3'b000, 1'b1);
    add("dsb_after",   2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0);

    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst.hold", {27'd0, pc_h, ifid_h, idex_h, exmem_h, memwb_h}, 32'h1F);
      check("rst.flush", {29'd0, ifid_f, idex_f, exmem_f}, 32'h0);
      check("rst.busy", {31'd0, busy}, 32'h0);
      check("rst.scnt", {16'd0, scnt}, 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel.hold", {27'd0, pc_h, ifid_h, idex_h, exmem_h, memwb_h}, 32'h0);
    check("rel.busy", {31'd0, busy}, 32'h0);
    check("rel.scnt", {16'd0, scnt}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // reset mid-divide on the DIV_CYCLES = 12 instance (CNT = 10 after the start edge)
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("rmd.pre_busy", {31'd0, l_busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    check("rmd.busy_cnt10", {31'd0, l_busy}, 32'h1);
    check("rmd.hold_cnt10", {31'd0, l_pc_h}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rmd.busy_in_rst", {31'd0, l_busy}, 32'h0);
    check("rmd.hold_in_rst", {27'd0, l_pc_h, l_ifid_h, l_idex_h, l_exmem_h, l_memwb_h}, 32'h1F);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rmd.run_busy", {31'd0, l_busy}, 32'h0);
    check("rmd.run_hold", {27'd0, l_pc_h, l_ifid_h, l_idex_h, l_exmem_h, l_memwb_h}, 32'h0);
    check("rmd.run_flush", {29'd0, l_ifid_f, l_idex_f, l_exmem_f}, 32'h0);
    check("rmd.main_hold", {31'd0, pc_h}, 32'h0);
    check("rmd.scnt", {16'd0, scnt}, 32'h0);

    // stall counter saturation and clear
    @(posedge clk); #1;
    imem = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat.fffe", {16'd0, scnt}, 32'hFFFE);
    @(posedge clk); #1;
    check("sat.ffff", {16'd0, scnt}, 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check("sat.hold", {16'd0, scnt}, 32'hFFFF);
    clr = 1'b1;
    @(posedge clk); #1;
    check("sat.clr", {16'd0, scnt}, 32'h0);
    clr = 1'b0;
    @(posedge clk); #1;
    check("sat.reinc", {16'd0, scnt}, 32'h1);
    imem = 1'b0;
    @(posedge clk); #1;
    check("sat.stop", {16'd0, scnt}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
